// File: rtl/apb_spi_master_bridge_if.sv
// apb_spi_master_bridge_if: groups the APB slave bus and the
// spi_master_driver handshake of apb_spi_master_bridge.
// The "slave" modport is the bridge's view; "master" is the view of whatever
// drives the bus and models the SPI driver.
`timescale 1ns/1ps

interface apb_spi_master_bridge_if;
  // APB side
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [3:0]  paddr_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  // spi_master_driver side
  logic        drv_start_o;
  logic [7:0]  drv_data_o;
  logic        drv_busy_i;
  logic [7:0]  drv_data_i;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o,
    output drv_start_o, drv_data_o,
    input  drv_busy_i, drv_data_i
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o,
    input  drv_start_o, drv_data_o,
    output drv_busy_i, drv_data_i
  );
endinterface

// File: rtl/apb_spi_master_bridge.sv
// apb_spi_master_bridge: APB slave in front of spi_master_driver.
// TXDATA writes are queued in a TX FIFO; a small engine hands bytes to the
// driver one at a time and pushes every received byte into an RX FIFO that
// the CPU drains through RXDATA.
// Optional feature: define APB_SPI_IRQ_EN to add the irq_o port and make
// CTRL bit1 (irq_en) writable.
`timescale 1ns/1ps

module apb_spi_master_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
`ifdef APB_SPI_IRQ_EN
  output logic irq_o,
`endif
  apb_spi_master_bridge_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    XFER    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_RXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_t;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic     access;
  reg_sel_t reg_sel;

  assign access  = bus.psel_i & bus.penable_i;
  assign reg_sel = reg_sel_t'(bus.paddr_i[3:2]);

  // Only byte lanes and word address bits that carry meaning are decoded.
  logic unused_bits;
  assign unused_bits = ^{bus.paddr_i[1:0], bus.pwdata_i[31:8]};

  // ---------------------------------------------------------------------------
  // FIFO storage and flags
  // ---------------------------------------------------------------------------
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CNT_W-1:0] tx_count;
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] rx_count;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] tx_head, rx_head;

  assign tx_full  = (tx_count == DEPTH);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == DEPTH);
  assign rx_empty = (rx_count == '0);
  assign tx_head  = tx_mem[tx_rd_ptr];
  assign rx_head  = rx_mem[rx_rd_ptr];

  // ---------------------------------------------------------------------------
  // Control register and engine state
  // ---------------------------------------------------------------------------
  logic   enable;
  logic   irq_en;
  state_t state, state_next;
  logic   drv_start_q, drv_start_next;
  logic [7:0] drv_data_q, drv_data_next;
  logic   engine_busy;

  assign engine_busy = (state != IDLE);

  // A rejected write (FIFO full) or read (FIFO empty) leaves the FIFO alone.
  assign tx_push = access &  bus.pwrite_i & (reg_sel == REG_TXDATA) & ~tx_full;
  assign rx_pop  = access & ~bus.pwrite_i & (reg_sel == REG_RXDATA) & ~rx_empty;
  assign tx_pop  = (state == START) & bus.drv_busy_i & ~tx_empty;
  assign rx_push = (state == CAPTURE) & ~rx_full;

  // TX FIFO: pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      // NOTE: the storage is cleared too, so a reset leaves no stale bytes
      // visible on the read port; a FIFO that only resets its pointers would
      // be cheaper but would expose old data at the head.
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere in clocked blocks, so every
      // register samples the pre-edge value of every other register.
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= bus.pwdata_i[7:0];
        tx_wr_ptr         <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO: filled by the engine, drained by RXDATA reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr_ptr] <= bus.drv_data_i;
        rx_wr_ptr         <= rx_wr_ptr + 1'b1;
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // CTRL register (and the optional registered interrupt).
`ifdef APB_SPI_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (access && bus.pwrite_i && reg_sel == REG_CTRL) begin
        enable <= bus.pwdata_i[0];
        irq_en <= bus.pwdata_i[1];
      end
      irq_q <= irq_en & (~rx_empty | tx_empty);
    end
  end

  assign irq_o = irq_q;
`else
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      enable <= 1'b0;
    end else if (access && bus.pwrite_i && reg_sel == REG_CTRL) begin
      enable <= bus.pwdata_i[0];
    end
  end

  assign irq_en = 1'b0;
`endif

  // Engine state and the registered driver-facing outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      drv_start_q <= 1'b0;
      drv_data_q  <= '0;
    end else begin
      state       <= state_next;
      drv_start_q <= drv_start_next;
      drv_data_q  <= drv_data_next;
    end
  end

  // Engine next state; start is raised one cycle after entering START and
  // dropped on the edge that sees the driver go busy.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next     = state;
    drv_start_next = 1'b0;
    drv_data_next  = drv_data_q;
    case (state)
      IDLE: begin
        if (enable && !tx_empty && !rx_full) state_next = START;
      end
      START: begin
        // The head is still the pre-pop byte on the popping edge, so the
        // value on drv_data_o does not change across the pop.
        drv_data_next = tx_head;
        if (bus.drv_busy_i) state_next = XFER;
        else                drv_start_next = 1'b1;
      end
      XFER: begin
        if (!bus.drv_busy_i) state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data is decoded from the address alone; an empty RXDATA reads 0.
  always_comb begin
    bus.prdata_o = '0;
    case (reg_sel)
      REG_RXDATA: if (!rx_empty) bus.prdata_o[7:0] = rx_head;
      REG_STATUS: bus.prdata_o[4:0] = {engine_busy, rx_empty, rx_full, tx_empty, tx_full};
      REG_CTRL:   bus.prdata_o[1:0] = {irq_en, enable};
      default:    bus.prdata_o = '0;
    endcase
  end

  assign bus.pslverr_o = access & (( bus.pwrite_i & (reg_sel == REG_TXDATA) & tx_full) |
                                   (~bus.pwrite_i & (reg_sel == REG_RXDATA) & rx_empty));
  assign bus.pready_o    = 1'b1;
  assign bus.drv_start_o = drv_start_q;
  assign bus.drv_data_o  = drv_data_q;

endmodule

// File: tb/tb_apb_spi_master_bridge.sv
// tb_apb_spi_master_bridge: directed sequence with random data for
// apb_spi_master_bridge. A behavioural SPI driver answers each start with a
// random reply after a random busy time; expected TX order and RX contents
// come from queues of accepted writes and generated replies.
`timescale 1ns/1ps

module tb_apb_spi_master_bridge;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  apb_spi_master_bridge_if bus();
`ifdef APB_SPI_IRQ_EN
  logic irq;
`endif

  apb_spi_master_bridge #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
`ifdef APB_SPI_IRQ_EN
    .irq_o   (irq),
`endif
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference queues
  logic [7:0] exp_tx_q[$];   // bytes accepted over APB, in order
  logic [7:0] sent_q[$];     // bytes the driver model was started with
  logic [7:0] reply_q[$];    // bytes the driver model returned, in order
  logic [7:0] preload_q[$];  // forced replies (otherwise random)
  int done_cnt;
  int xfer_min;
  int xfer_max;

  // Behavioural spi_master_driver: sees start, goes busy for a while,
  // returns a byte and drops busy. Reset by the same net as the bridge.
  initial begin
    int cnt;
    logic [7:0] cur_byte;
    logic [7:0] reply;
    cnt = 0;
    cur_byte = '0;
    bus.drv_busy_i = 1'b0;
    bus.drv_data_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.drv_busy_i = 1'b0;
        cnt = 0;
      end else if (bus.drv_busy_i) begin
        if (cnt > 0) cnt--;
        else begin
          check("drv_data_held", {24'b0, bus.drv_data_o}, {24'b0, cur_byte});
          if (preload_q.size() > 0) reply = preload_q.pop_front();
          else                      reply = 8'($urandom);
          bus.drv_data_i = reply;
          reply_q.push_back(reply);
          bus.drv_busy_i = 1'b0;
          done_cnt++;
        end
      end else if (bus.drv_start_o === 1'b1) begin
        cur_byte = bus.drv_data_o;
        sent_q.push_back(cur_byte);
        bus.drv_busy_i = 1'b1;
        cnt = $urandom_range(xfer_max, xfer_min);
      end
    end
  end

  // One APB transfer: setup phase, access phase sampled mid-cycle.
  task automatic apb(input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(negedge clk);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0;
    bus.pwrite_i = w; bus.paddr_i = a; bus.pwdata_i = d;
    @(negedge clk);
    bus.penable_i = 1'b1;
    #1;
    rd  = bus.prdata_o;
    err = bus.pslverr_o;
    @(posedge clk);
    #1;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int i;
    i = 0;
    while (done_cnt < n && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check(tag, done_cnt, n);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_sent(input string tag);
    while (sent_q.size() > 0) begin
      if (exp_tx_q.size() == 0) begin
        check({tag, "_extra"}, sent_q.size(), 0);
        sent_q.delete();
      end else begin
        check(tag, {24'b0, sent_q.pop_front()}, {24'b0, exp_tx_q.pop_front()});
      end
    end
  endtask

  task automatic check_rx(input int n, input string tag);
    logic [31:0] rd;
    logic err;
    logic [7:0] e;
    logic e_err;
    for (int i = 0; i < n; i++) begin
      apb(1'b0, 4'h4, 32'h0, rd, err);
      e_err = (reply_q.size() == 0);
      e = e_err ? 8'h00 : reply_q.pop_front();
      check(tag, rd, {24'b0, e});
      check({tag, "_err"}, {31'b0, err}, {31'b0, e_err});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic err;
  logic [7:0] b;
  int base;
  int k;

  initial begin
    n_cmp = 0; n_fail = 0; done_cnt = 0;
    xfer_min = 1; xfer_max = 4;
    bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0;
    bus.paddr_i = '0; bus.pwdata_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_drv_start", {31'b0, bus.drv_start_o}, 0);
    check("rst_drv_data", {24'b0, bus.drv_data_o}, 0);
    check("rst_pready", {31'b0, bus.pready_o}, 1);
    check("rst_pslverr", {31'b0, bus.pslverr_o}, 0);
    rst_n = 1'b1;
    apb(1'b0, 4'h8, 0, rd, err);
    check("rst_status", rd, 32'h0A);
    check("rst_status_err", {31'b0, err}, 0);
    apb(1'b0, 4'hC, 0, rd, err);
    check("rst_ctrl", rd, 0);
`ifdef APB_SPI_IRQ_EN
    check("rst_irq", {31'b0, irq}, 0);
    apb(1'b1, 4'hC, 32'h2, rd, err);
    repeat (2) @(negedge clk);
    check("irq_tx_empty", {31'b0, irq}, 1);
    apb(1'b0, 4'hC, 0, rd, err);
    check("ctrl_irq_en", rd, 32'h2);
    apb(1'b1, 4'hC, 32'h0, rd, err);
`endif

    // Empty RX read
    apb(1'b0, 4'h4, 0, rd, err);
    check("empty_rd_err", {31'b0, err}, 1);
    check("empty_rd_data", rd, 0);
    apb(1'b0, 4'h8, 0, rd, err);
    check("empty_rd_status", rd, 32'h0A);

    // Single byte
    preload_q.push_back(8'hA3);
    apb(1'b1, 4'hC, 32'h1, rd, err);
    exp_tx_q.push_back(8'h35);
    apb(1'b1, 4'h0, 32'h35, rd, err);
    check("single_wr_err", {31'b0, err}, 0);
    @(posedge clk); #1;
    check("start_n1", {31'b0, bus.drv_start_o}, 0);
    @(posedge clk); #1;
    check("start_n2", {31'b0, bus.drv_start_o}, 1);
    check("data_n2", {24'b0, bus.drv_data_o}, 32'h35);
    wait_done(1, "single_done");
    check_sent("single_sent");
    check_rx(1, "single_rx");
    apb(1'b0, 4'h8, 0, rd, err);
    check("single_status", rd, 32'h0A);
    apb(1'b0, 4'h0, 0, rd, err);
    check("txdata_read", rd, 0);

    // TX full with engine disabled
    apb(1'b1, 4'hC, 32'h0, rd, err);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      apb(1'b1, 4'h0, {24'b0, b}, rd, err);
      if (i < DEPTH) exp_tx_q.push_back(b);
      check("txfull_wr_err", {31'b0, err}, {31'b0, (i >= DEPTH)});
    end
    apb(1'b0, 4'h8, 0, rd, err);
    check("txfull_status", rd, 32'h09);
    base = done_cnt;
    apb(1'b1, 4'hC, 32'h1, rd, err);
    wait_done(base + DEPTH, "txfull_done");
    check_sent("txfull_sent");
    check_rx(DEPTH, "txfull_rx");
    apb(1'b0, 4'h8, 0, rd, err);
    check("txfull_end_status", rd, 32'h0A);

    // RX full stall: six bytes queued, never read
    base = done_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) wait_done(base + 2, "stall_pre");
      b = 8'($urandom);
      exp_tx_q.push_back(b);
      apb(1'b1, 4'h0, {24'b0, b}, rd, err);
      check("stall_wr_err", {31'b0, err}, 0);
    end
    wait_done(base + DEPTH, "stall_done4");
    repeat (100) @(negedge clk);
    check("stall_count", done_cnt, base + DEPTH);
    apb(1'b0, 4'h8, 0, rd, err);
    check("stall_status", rd, 32'h04);
    check_sent("stall_sent");
    check_rx(1, "stall_rx1");
    wait_done(base + 5, "stall_done5");
    check_rx(DEPTH, "stall_rx4");
    wait_done(base + 6, "stall_done6");
    check_rx(1, "stall_rx_last");
    check_sent("stall_sent_rest");
    apb(1'b0, 4'h8, 0, rd, err);
    check("stall_end_status", rd, 32'h0A);

    // Reset in the middle of a transfer
    xfer_min = 8; xfer_max = 8;
    apb(1'b1, 4'h0, {24'b0, 8'($urandom)}, rd, err);
    k = 0;
    while (bus.drv_busy_i !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("midrst_busy", {31'b0, bus.drv_busy_i}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_start", {31'b0, bus.drv_start_o}, 0);
    check("midrst_data", {24'b0, bus.drv_data_o}, 0);
    check("midrst_pslverr", {31'b0, bus.pslverr_o}, 0);
    bus.paddr_i = 4'h8; #1;
    check("midrst_status", bus.prdata_o, 32'h0A);
    bus.paddr_i = 4'hC; #1;
    check("midrst_ctrl", bus.prdata_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_tx_q.delete();
    sent_q.delete();
    xfer_min = 1; xfer_max = 4;
    base = done_cnt;
    apb(1'b1, 4'hC, 32'h1, rd, err);
    exp_tx_q.push_back(8'h5A);
    apb(1'b1, 4'h0, 32'h5A, rd, err);
    wait_done(base + 1, "post_rst_done");
    check_sent("post_rst_sent");
    check_rx(1, "post_rst_rx");
    apb(1'b0, 4'h8, 0, rd, err);
    check("post_rst_status", rd, 32'h0A);

    // Random bursts
    for (int r = 0; r < 4; r++) begin
      base = done_cnt;
      k = $urandom_range(DEPTH, 1);
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        exp_tx_q.push_back(b);
        apb(1'b1, 4'h0, {24'b0, b}, rd, err);
        check("rand_wr_err", {31'b0, err}, 0);
      end
      wait_done(base + k, "rand_done");
      check_sent("rand_sent");
      check_rx(k, "rand_rx");
    end
    apb(1'b0, 4'h8, 0, rd, err);
    check("final_status", rd, 32'h0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_spi_master_bridge.md
# apb_spi_master_bridge

APB slave that fronts `spi_master_driver`, turning CPU register accesses into SPI byte transfers. Bytes written over APB are queued in a TX FIFO. A transfer engine feeds them one at a time to the master driver's `start_i`/`data_in_bi`/`busy_o` handshake. Each byte received on `data_out_bo` is pushed into an RX FIFO that the CPU reads back. The block sits between the AMBA interconnect and the SPI master driver.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries in each of the TX and RX FIFOs; power of two, 2..16.

Ports (clock is `clk_i`; reset is `rst_n_i`, asynchronous and active-low):
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `psel_i`  in  1  APB select.
- `penable_i`  in  1  APB enable (access phase).
- `pwrite_i`  in  1  APB write when 1.
- `paddr_i`  in  4  byte address; only bits [3:2] are decoded.
- `pwdata_i`  in  32  APB write data.
- `prdata_o`  out  32  APB read data, combinational from the address.
- `pready_o`  out  1  tied to 1 (no wait states).
- `pslverr_o`  out  1  error response, valid in the access phase.
- `drv_start_o`  out  1  to `spi_master_driver.start_i`.
- `drv_data_o`  out  8  to `spi_master_driver.data_in_bi`.
- `drv_busy_i`  in  1  from `spi_master_driver.busy_o`.
- `drv_data_i`  in  8  from `spi_master_driver.data_out_bo`.
- `irq_o`  out  1  interrupt; present only with `APB_SPI_IRQ_EN` (see Configuration).

## Operation
Register map (an APB access is a cycle with `psel_i & penable_i` high):
- 0x0 TXDATA: a write pushes `pwdata_i[7:0]`; a read returns 0.
- 0x4 RXDATA: a read returns `{24'b0, head}` and pops the RX FIFO; writes are ignored.
- 0x8 STATUS (read-only): bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 engine_busy (state not IDLE); other bits 0.
- 0xC CTRL (read/write): bit0 enable, bit1 irq_en; resets to 0.

Error responses:
- `pslverr_o`=1 on a TXDATA write while tx_full. Data is dropped and the FIFO is unchanged.
- `pslverr_o`=1 on an RXDATA read while rx_empty. The read returns 0 and there is no pop.
- `pslverr_o`=0 for every other access.

FIFOs:
- Pointers wrap modulo `FIFO_DEPTH`.
- Each count runs 0..`FIFO_DEPTH`.
- A push and a pop in the same cycle leave the count unchanged; the data is still written and read.

Transfer engine states:
- IDLE → START when enable=1, !tx_empty and !rx_full. The engine stalls, never overflows, while the RX FIFO is full.
- START: `drv_data_o` = TX FIFO head; `drv_start_o`=1. On `drv_busy_i`=1: pop TX, go to XFER. `drv_data_o` is held stable across the pop.
- XFER: `drv_start_o`=0. On `drv_busy_i`=0 → CAPTURE.
- CAPTURE: push `drv_data_i` into the RX FIFO, go to IDLE.

Other rules:
- Clearing `enable` mid-transfer does not abort the transfer; the engine stops at the next IDLE.

## Timing
Reset values:
- `prdata_o`=0 (address-decoded), `pslverr_o`=0, `pready_o`=1.
- `drv_start_o`=0, `drv_data_o`=0, `irq_o`=0.
- State IDLE; both FIFOs empty; CTRL=0.

Latency:
- A TXDATA write in cycle N updates the FIFO at edge N.
- `drv_start_o` rises at edge N+2 when the engine was IDLE and enabled.
- The byte is in the RX FIFO one cycle after `drv_busy_i` falls.

Registered timing:
- `drv_start_o` and `drv_data_o` are registered.
- STATUS reflects register state as of the previous edge.

Reset mid-operation: `rst_n_i` low clears everything immediately, including FIFO contents and an in-flight transfer. The driver is reset by the same net.

## Configuration
- `APB_SPI_IRQ_EN` defined:
  - Port `irq_o` exists; it is a register equal to `irq_en & (!rx_empty | tx_empty)` from the previous cycle.
  - CTRL bit1 is writable.
- `APB_SPI_IRQ_EN` undefined:
  - Port `irq_o` is absent.
  - CTRL bit1 reads 0 and ignores writes.

## Test plan
- Reset: hold `rst_n_i`=0, then release → STATUS=0x0A, `drv_start_o`=0, CTRL reads 0.
- Single byte:
  - Stimulus: CTRL=1, TXDATA=0x35; slave loaded with 0xA3.
  - Required response: `drv_data_o`=0x35 with `drv_start_o` pulse held until busy; after busy falls, RXDATA reads 0xA3 and STATUS=0x0A.
- TX full: with enable=0, write 5 bytes at `FIFO_DEPTH`=4 → the 5th write gets `pslverr_o`=1 and STATUS bit0=1. Set enable → 4 transfers run in order.
- RX full stall: with enable=1, queue 6 bytes and never read → exactly 4 transfers, engine IDLE with tx holding 2. Read RXDATA once → the 5th transfer starts.
- Empty read: RXDATA read on reset state → `pslverr_o`=1, `prdata_o`=0.
- Mid-transfer reset: assert `rst_n_i` during XFER → all outputs at reset values next cycle; a subsequent transfer with 0x5A completes normally.
